// File: rtl/alu_packet_core_if.sv
// Byte-stream bundle for alu_packet_core: inbound and outbound valid/ready byte
// channels, plus the busy and error status lines.
interface alu_packet_core_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/alu_packet_core.sv
// Byte-stream packet ALU: parses a 4-byte header {opcode, reserved, len_lo, len_hi},
// then echoes, sums or multiplies big-endian operands and returns the result MSB first.
module alu_packet_core #(
  parameter int unsigned OPERAND_BYTES = 4,
  parameter logic [7:0]  OP_ECHO       = 8'hEC,
  parameter logic [7:0]  OP_ADD        = 8'hAD,
  parameter logic [7:0]  OP_MUL        = 8'h88
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_packet_core_if.slave bus
);
  localparam int unsigned   W        = 8 * OPERAND_BYTES;
  localparam int unsigned   IW       = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(OPERAND_BYTES - 1);

  typedef enum logic [2:0] {
    HDR_OP  = 3'd0,
    HDR_RSV = 3'd1,
    HDR_LO  = 3'd2,
    HDR_HI  = 3'd3,
    ECHO    = 3'd4,
    ACC     = 3'd5,
    DRAIN   = 3'd6,
    RESULT  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   plen_q, plen_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  opnd_q, opnd_d;
  // Operand byte index while accumulating, result byte index while transmitting.
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic [15:0]   len_full;
  logic [15:0]   plen_hdr;
  logic [W-1:0]  opnd_shift;
  logic          last_payload;
  logic          is_mul;
  logic [7:0]    acc_bytes [OPERAND_BYTES];

  // Big-endian view of the accumulator: entry 0 is the most significant byte.
  for (genvar gi = 0; gi < OPERAND_BYTES; gi++) begin : g_acc_bytes
    assign acc_bytes[gi] = acc_q[W-1-8*gi -: 8];
  end

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    len_lo_d       = len_lo_q;
    plen_d         = plen_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    opnd_d         = opnd_q;
    idx_d          = idx_q;
    err_d          = 1'b0;
    bus.rx_ready_o = 1'b0;
    bus.tx_valid_o = 1'b0;
    bus.tx_data_o  = 8'h00;

    len_full     = {bus.rx_data_i, len_lo_q};
    plen_hdr     = (len_full < 16'd4) ? 16'd0 : (len_full - 16'd4);
    opnd_shift   = (opnd_q << 8) | W'(bus.rx_data_i);
    last_payload = (cnt_q == (plen_q - 16'd1));
    is_mul       = (opcode_q == OP_MUL);

    unique case (state_q)
      HDR_OP: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) begin
          opcode_d = bus.rx_data_i;
          state_d  = HDR_RSV;
        end
      end
      HDR_RSV: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) state_d = HDR_LO;
      end
      HDR_LO: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) begin
          len_lo_d = bus.rx_data_i;
          state_d  = HDR_HI;
        end
      end
      HDR_HI: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) begin
          plen_d = plen_hdr;
          cnt_d  = 16'd0;
          idx_d  = '0;
          opnd_d = '0;
          acc_d  = is_mul ? W'(1) : '0;
          if (len_full < 16'd4) err_d = 1'b1;
          if (opcode_q == OP_ECHO) begin
            state_d = (plen_hdr == 16'd0) ? HDR_OP : ECHO;
          end else if ((opcode_q == OP_ADD) || is_mul) begin
            state_d = (plen_hdr == 16'd0) ? RESULT : ACC;
          end else begin
            err_d   = 1'b1;
            state_d = (plen_hdr == 16'd0) ? HDR_OP : DRAIN;
          end
        end
      end
      ECHO: begin
        // Straight combinational pass-through; rx stalls whenever tx is backpressured.
        bus.tx_data_o  = bus.rx_data_i;
        bus.tx_valid_o = bus.rx_valid_i;
        bus.rx_ready_o = bus.tx_ready_i;
        if (bus.rx_valid_i && bus.tx_ready_i) begin
          cnt_d = cnt_q + 16'd1;
          if (last_payload) state_d = HDR_OP;
        end
      end
      ACC: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) begin
          cnt_d = cnt_q + 16'd1;
          if (idx_q == LAST_IDX) begin
            acc_d  = is_mul ? (acc_q * opnd_shift) : (acc_q + opnd_shift);
            opnd_d = '0;
            idx_d  = '0;
          end else begin
            opnd_d = opnd_shift;
            idx_d  = idx_q + IW'(1);
          end
          if (last_payload) begin
            // A trailing operand that never completed is dropped and flagged.
            if (idx_q != LAST_IDX) err_d = 1'b1;
            opnd_d  = '0;
            idx_d   = '0;
            state_d = RESULT;
          end
        end
      end
      DRAIN: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) begin
          cnt_d = cnt_q + 16'd1;
          if (last_payload) state_d = HDR_OP;
        end
      end
      RESULT: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = acc_bytes[idx_q];
        if (bus.tx_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = HDR_OP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = HDR_OP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HDR_OP;
      opcode_q <= 8'h00;
      len_lo_q <= 8'h00;
      plen_q   <= 16'd0;
      cnt_q    <= 16'd0;
      acc_q    <= '0;
      opnd_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_lo_q <= len_lo_d;
      plen_q   <= plen_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy_o = (state_q != HDR_OP);
  // Masked so a pulse left over from the previous cycle never overlaps reset.
  assign bus.err_o  = err_q & ~rst_i;

endmodule

// File: tb/tb_alu_packet_core.sv
// Scoreboard bench for alu_packet_core: a 32-bit instance for echo/add/error cases
// and a 16-bit instance for multiply; one stimulus driver muxed between them.
`timescale 1ns/1ps
module tb_alu_packet_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic       sel16    = 1'b0;
  int         ready_mode = 0;  // 0 always ready, 1 random, 2 driven by main sequence

  alu_packet_core_if if32();
  alu_packet_core_if if16();

  assign if32.rx_data_i  = rx_data;
  assign if32.rx_valid_i = rx_valid & ~sel16;
  assign if32.tx_ready_i = tx_ready;
  assign if16.rx_data_i  = rx_data;
  assign if16.rx_valid_i = rx_valid & sel16;
  assign if16.tx_ready_i = tx_ready;

  alu_packet_core #(.OPERAND_BYTES(4)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));
  alu_packet_core #(.OPERAND_BYTES(2)) u_dut16 (.clk_i(clk), .rst_i(rst), .bus(if16));

  wire       s_rx_ready = sel16 ? if16.rx_ready_o : if32.rx_ready_o;
  wire       s_tx_valid = sel16 ? if16.tx_valid_o : if32.tx_valid_o;
  wire [7:0] s_tx_data  = sel16 ? if16.tx_data_o  : if32.tx_data_o;
  wire       s_busy     = sel16 ? if16.busy_o     : if32.busy_o;
  wire       s_err      = sel16 ? if16.err_o      : if32.err_o;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pkt [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: compares each accepted tx byte with the scoreboard, counts err pulses.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s_err) err_cnt++;
        if (s_tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("tx_extra_byte", 64'(s_tx_data), 64'h100);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 64'(s_tx_data), 64'(e));
            $display("tx byte %02h (expected %02h)", s_tx_data, e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) tx_ready = 1'b1;
      else if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_rx_ready) break;
      t++;
      if (t > 2000) begin
        check("rx_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] op, input int len);
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'h00);
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
  endtask

  task automatic put_word(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) pkt.push_back(v[8*i +: 8]);
  endtask

  task automatic expect_word(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  // Waits for the scoreboard to empty and the core to return to idle, then checks errors.
  task automatic finish_pkt(input string tag, input int err_base, input int err_exp);
    int t = 0;
    while ((exp_q.size() != 0 || s_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle_txv"}, 64'(s_tx_valid), 64'd0);
    check({tag, "_err_pulses"}, 64'(err_cnt - err_base), 64'(err_exp));
    $display("packet %s done: err pulses %0d", tag, err_cnt - err_base);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int eb;
    logic [31:0] a, b, c, s32;
    logic [15:0] x, y, z, p16;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 64'(if32.rx_ready_o), 64'd1);
    check("rst_tx_valid", 64'(if32.tx_valid_o), 64'd0);
    check("rst_tx_data", 64'(if32.tx_data_o), 64'd0);
    check("rst_busy", 64'(if32.busy_o), 64'd0);
    check("rst_err", 64'(if32.err_o), 64'd0);
    check("rst16_busy", 64'(if16.busy_o), 64'd0);
    @(posedge clk);
    #1;

    // Echo, always ready
    eb = err_cnt;
    hdr(8'hEC, 7); pkt.push_back(8'h41); pkt.push_back(8'h42); pkt.push_back(8'h43);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    send_pkt();
    finish_pkt("echo", eb, 0);

    // Echo with random backpressure
    ready_mode = 1;
    eb = err_cnt;
    hdr(8'hEC, 4 + 12);
    for (int i = 0; i < 12; i++) begin
      pkt.push_back(8'($urandom));
      exp_q.push_back(pkt[pkt.size() - 1]);
    end
    send_pkt();
    finish_pkt("echo_bp", eb, 0);
    ready_mode = 0;

    eb = err_cnt;
    hdr(8'hAD, 12); put_word(1, 4); put_word(2, 4); expect_word(32'h3, 4);
    send_pkt();
    finish_pkt("add", eb, 0);

    eb = err_cnt;
    hdr(8'hAD, 4); expect_word(32'h0, 4);
    send_pkt();
    finish_pkt("add_empty", eb, 0);

    eb = err_cnt;
    hdr(8'hAD, 12); put_word(32'hFFFF_FFFF, 4); put_word(2, 4); expect_word(32'h1, 4);
    send_pkt();
    finish_pkt("add_wrap", eb, 0);

    eb = err_cnt;
    hdr(8'h55, 6); pkt.push_back(8'h12); pkt.push_back(8'h34);
    send_pkt();
    finish_pkt("drain", eb, 1);

    eb = err_cnt;
    hdr(8'hAD, 7); pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
    expect_word(32'h0, 4);
    send_pkt();
    finish_pkt("add_partial", eb, 1);

    eb = err_cnt;
    hdr(8'hEC, 2);
    send_pkt();
    finish_pkt("short_len", eb, 1);

    // Random add with random backpressure
    ready_mode = 1;
    a = $urandom; b = $urandom; c = $urandom;
    s32 = a + b + c;
    eb = err_cnt;
    hdr(8'hAD, 16); put_word(a, 4); put_word(b, 4); put_word(c, 4); expect_word(s32, 4);
    send_pkt();
    finish_pkt("add_rand", eb, 0);
    ready_mode = 0;

    // Multiply on the 16-bit instance
    sel16 = 1'b1;
    eb = err_cnt;
    hdr(8'h88, 10); put_word(16'h0003, 2); put_word(16'h0005, 2); put_word(16'h0100, 2);
    expect_word(16'h0F00, 2);
    send_pkt();
    finish_pkt("mul16", eb, 0);

    eb = err_cnt;
    hdr(8'h88, 4); expect_word(16'h0001, 2);
    send_pkt();
    finish_pkt("mul16_empty", eb, 0);

    ready_mode = 1;
    x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
    p16 = x * y;
    p16 = p16 * z;
    eb = err_cnt;
    hdr(8'h88, 10); put_word(x, 2); put_word(y, 2); put_word(z, 2); expect_word(p16, 2);
    send_pkt();
    finish_pkt("mul16_rand", eb, 0);
    ready_mode = 0;
    sel16 = 1'b0;

    // Reset while the second result byte is pending
    ready_mode = 2;
    tx_ready = 1'b0;
    hdr(8'hAD, 12); put_word(5, 4); put_word(6, 4);
    exp_q.push_back(8'h00);
    send_pkt();
    begin
      int t = 0;
      while (!s_tx_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("result_valid", 64'(s_tx_valid), 64'd1);
    end
    @(posedge clk); #1; tx_ready = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    @(negedge clk);
    check("result_hold_valid", 64'(s_tx_valid), 64'd1);
    check("result_byte2", 64'(s_tx_data), 64'h00);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rst_no_err", 64'(s_err), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_tx_valid", 64'(s_tx_valid), 64'd0);
    check("abort_busy", 64'(s_busy), 64'd0);
    check("abort_rx_ready", 64'(s_rx_ready), 64'd1);
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    ready_mode = 0;
    tx_ready = 1'b1;

    eb = err_cnt;
    hdr(8'hAD, 12); put_word(32'h1234_5678, 4); put_word(32'h1111_1111, 4);
    expect_word(32'h2345_6789, 4);
    send_pkt();
    finish_pkt("add_after_rst", eb, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
